// File: rtl/vga_pkg.sv
// Shared VGA frame-buffer constants and types, used by the drawing logic,
// the scan-out logic and the frame memory.
package vga_pkg;

  localparam int unsigned VGA_ADDR_W = 16;
  localparam int unsigned VGA_DATA_W = 8;

  typedef logic [VGA_ADDR_W-1:0] vga_addr_t;
  typedef logic [VGA_DATA_W-1:0] vga_data_t;

endpackage

// File: rtl/vga_mem_array.sv
// Plain 1-write/2-read storage array for the frame buffer, zero at power-up
// and never reset. Outputs are combinational; the wrapper registers them.
module vga_mem_array
  import vga_pkg::*;
#(
  parameter int unsigned ADDR_W = VGA_ADDR_W,
  parameter int unsigned DATA_W = VGA_DATA_W,
  parameter int unsigned DEPTH  = 2 ** ADDR_W
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr_a,
  input  logic [ADDR_W-1:0] raddr_b,
  output logic [DATA_W-1:0] rdata_a,
  output logic [DATA_W-1:0] rdata_b
);

  logic [DATA_W-1:0] mem [DEPTH] = '{default: '0};

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  always_comb begin
    rdata_a = mem[raddr_a];
    rdata_b = mem[raddr_b];
  end

endmodule

// File: rtl/vga_mem.sv
// Dual-port VGA frame memory: port A read/write (write-first), port B read-only
// with same-address bypass from A, both with registered, async-cleared outputs.
module vga_mem
  import vga_pkg::*;
#(
  parameter int unsigned ADDR_W = VGA_ADDR_W,
  parameter int unsigned DATA_W = VGA_DATA_W,
  parameter int unsigned DEPTH  = 2 ** ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] data_a,
  input  logic [ADDR_W-1:0] addr_a,
  input  logic [ADDR_W-1:0] addr_b,
  input  logic              we_a,
  output logic [DATA_W-1:0] q_a,
  output logic [DATA_W-1:0] q_b
);

  logic              we_gated;
  logic              bypass_b;
  logic [DATA_W-1:0] rd_a;
  logic [DATA_W-1:0] rd_b;

  // Writes are dropped while reset is held, so the array keeps its contents.
  always_comb begin
    we_gated = we_a & rst_n;
    bypass_b = we_a && (addr_b == addr_a);
  end

  vga_mem_array #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_array (
    .clk     (clk),
    .we      (we_gated),
    .waddr   (addr_a),
    .wdata   (data_a),
    .raddr_a (addr_a),
    .raddr_b (addr_b),
    .rdata_a (rd_a),
    .rdata_b (rd_b)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_a <= '0;
      q_b <= '0;
    end else begin
      q_a <= we_a     ? data_a : rd_a;
      q_b <= bypass_b ? data_a : rd_b;
    end
  end

endmodule

// File: tb/tb_vga_mem.sv
// Self-checking bench for vga_mem against a memory-array reference model.
`timescale 1ns/1ps
module tb_vga_mem;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  data_a;
  logic [15:0] addr_a;
  logic [15:0] addr_b;
  logic        we_a;
  logic [7:0]  q_a;
  logic [7:0]  q_b;

  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  // Reference: memory contents and the values each port should show.
  logic [7:0] model [65536] = '{default: 8'h00};
  logic [7:0] exp_a;
  logic [7:0] exp_b;

  vga_mem #(
    .ADDR_W (16),
    .DATA_W (8),
    .DEPTH  (65536)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .data_a (data_a),
    .addr_a (addr_a),
    .addr_b (addr_b),
    .we_a   (we_a),
    .q_a    (q_a),
    .q_b    (q_b)
  );

  always #5 clk = ~clk;

  // One rising edge; the model applies the write, then each port shows the
  // memory word at its address (which already includes this cycle's write).
  task automatic step();
    @(posedge clk);
    if (rst_n) begin
      if (we_a) model[addr_a] = data_a;
      exp_a = model[addr_a];
      exp_b = model[addr_b];
    end else begin
      exp_a = 8'h00;
      exp_b = 8'h00;
    end
    #1;
  endtask

  task automatic drive(input logic we, input logic [15:0] aa,
                       input logic [15:0] ab, input logic [7:0] d);
    we_a   = we;
    addr_a = aa;
    addr_b = ab;
    data_a = d;
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    drive(1'b1, 16'h0003, 16'h0004, 8'hEE);
    #1 rst_n = 1'b0;
    #1;
    vectors++;
    if (q_a !== 8'h00 || q_b !== 8'h00) begin
      miscompares++;
      $display("FAIL reset_async: q_a=%h q_b=%h expected 00 00", q_a, q_b);
    end
    step();
    #2 rst_n = 1'b1;
    drive(1'b0, 16'd5, 16'd5, 8'h77);
    step();
    vectors++;
    if (q_a !== 8'h00 || q_b !== 8'h00) begin
      miscompares++;
      $display("FAIL powerup_zero: q_a=%h q_b=%h expected 00 00", q_a, q_b);
    end
    drive(1'b0, 16'd3, 16'd3, 8'h00);
    step();
    vectors++;
    if (q_a !== 8'h00) begin
      miscompares++;
      $display("FAIL write_in_reset_dropped: q_a=%h expected 00", q_a);
    end
  endtask

  task automatic test_write_read();
    drive(1'b1, 16'd0, 16'd9, 8'd200);
    step();
    vectors++;
    if (q_a !== 8'd200) begin
      miscompares++;
      $display("FAIL write_first_a: q_a=%0d expected 200", q_a);
    end
    drive(1'b0, 16'd9, 16'd0, 8'd0);
    step();
    vectors++;
    if (q_b !== 8'd200) begin
      miscompares++;
      $display("FAIL read_b_after_write: q_b=%0d expected 200", q_b);
    end
  endtask

  task automatic test_bypass();
    drive(1'b1, 16'd1, 16'd1, 8'd37);
    step();
    vectors++;
    if (q_a !== 8'd37 || q_b !== 8'd37) begin
      miscompares++;
      $display("FAIL bypass_same_addr: q_a=%0d q_b=%0d expected 37 37", q_a, q_b);
    end
  endtask

  task automatic test_independent();
    drive(1'b1, 16'd23, 16'd0, 8'd37); step();
    drive(1'b1, 16'd24, 16'd0, 8'd99); step();
    drive(1'b0, 16'd23, 16'd24, 8'd0); step();
    vectors++;
    if (q_a !== 8'd37 || q_b !== 8'd99) begin
      miscompares++;
      $display("FAIL independent_reads: q_a=%0d q_b=%0d expected 37 99", q_a, q_b);
    end
    drive(1'b0, 16'd24, 16'd23, 8'd0); step();
    vectors++;
    if (q_a !== 8'd99 || q_b !== 8'd37) begin
      miscompares++;
      $display("FAIL independent_swap: q_a=%0d q_b=%0d expected 99 37", q_a, q_b);
    end
  endtask

  task automatic test_sweep();
    logic [15:0] a;
    for (int i = 0; i < 2096; i++) begin
      a = i[15:0];
      drive(1'b1, a, a, a[7:0]);
      step();
      vectors++;
      if (q_a !== a[7:0] || q_b !== a[7:0]) begin
        miscompares++;
        $display("FAIL sweep_write @%0d: q_a=%h q_b=%h expected %h", i, q_a, q_b, a[7:0]);
      end
      drive(1'b0, a, a, 8'h00);
      step();
    end
    for (int i = 0; i < 2096; i++) begin
      a = i[15:0];
      drive(1'b0, 16'hFFF0, a, 8'h00);
      step();
      vectors++;
      if (q_b !== a[7:0]) begin
        miscompares++;
        $display("FAIL sweep_read_b @%0d: q_b=%h expected %h", i, q_b, a[7:0]);
      end
    end
    drive(1'b1, 16'hFFFF, 16'h0000, 8'hC3); step();
    drive(1'b0, 16'hFFFF, 16'hFFFF, 8'h00); step();
    vectors++;
    if (q_a !== 8'hC3 || q_b !== 8'hC3) begin
      miscompares++;
      $display("FAIL top_address: q_a=%h q_b=%h expected c3 c3", q_a, q_b);
    end
  endtask

  task automatic test_reset_retention();
    drive(1'b1, 16'd7, 16'd7, 8'h5A); step();
    vectors++;
    if (q_a !== 8'h5A || q_b !== 8'h5A) begin
      miscompares++;
      $display("FAIL pre_reset_write: q_a=%h q_b=%h expected 5a 5a", q_a, q_b);
    end
    drive(1'b0, 16'd7, 16'd7, 8'h00);
    rst_n = 1'b0;
    #1;
    vectors++;
    if (q_a !== 8'h00 || q_b !== 8'h00) begin
      miscompares++;
      $display("FAIL reset_pulse_async: q_a=%h q_b=%h expected 00 00", q_a, q_b);
    end
    drive(1'b1, 16'd7, 16'd7, 8'h11);
    step();
    vectors++;
    if (q_a !== 8'h00 || q_b !== 8'h00) begin
      miscompares++;
      $display("FAIL held_in_reset: q_a=%h q_b=%h expected 00 00", q_a, q_b);
    end
    drive(1'b0, 16'd7, 16'd7, 8'h00);
    #2 rst_n = 1'b1;
    step();
    vectors++;
    if (q_a !== 8'h5A || q_b !== 8'h5A) begin
      miscompares++;
      $display("FAIL retained_after_reset: q_a=%h q_b=%h expected 5a 5a", q_a, q_b);
    end
  endtask

  task automatic test_random();
    logic [15:0] aa;
    logic [15:0] ab;
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 9) == 0) begin
        aa = 16'($urandom);
        ab = 16'($urandom);
      end else begin
        aa = 16'h4000 + 16'($urandom_range(0, 7));
        ab = 16'h4000 + 16'($urandom_range(0, 7));
      end
      drive(1'($urandom_range(0, 1)), aa, ab, 8'($urandom));
      step();
      vectors++;
      if (q_a !== exp_a || q_b !== exp_b) begin
        miscompares++;
        $display("FAIL random @%0d: q_a=%h q_b=%h expected %h %h", n, q_a, q_b, exp_a, exp_b);
      end
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_bypass();
    test_independent();
    test_sweep();
    test_reset_retention();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
